// File: rtl/bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Shares one single-port BRAM between two requesters (A, B).
//               Round-robin arbitration with a per-owner burst limit, fully
//               registered BRAM drive, and read data returned to the issuing
//               requester through a tag pipeline matched to the BRAM latency.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk                    single clock, rising edge
//   rstn                   asynchronous active-low reset
//   i_X_Req/Wr/Addr/WData  requester X transfer request (X = A, B)
//   o_X_Gnt                combinational grant; transfer on edge with Req&Gnt
//   o_X_RValid/RData       one-cycle read return strobe and data
//   o_Addr/EN/WEN/WData    registered BRAM controls
//   i_RData                BRAM read data, RD_LAT cycles after sampling edge
// ============================================================================
module bram_port_arbiter #(
    parameter int ADDR_SIZE = 16,
    parameter int DATA_SIZE = 32,
    parameter int WEN_SIZE  = 4,
    parameter int RD_LAT    = 2,
    parameter int MAX_BURST = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 i_A_Req,
    input  logic                 i_A_Wr,
    input  logic [ADDR_SIZE-1:0] i_A_Addr,
    input  logic [DATA_SIZE-1:0] i_A_WData,
    input  logic                 i_B_Req,
    input  logic                 i_B_Wr,
    input  logic [ADDR_SIZE-1:0] i_B_Addr,
    input  logic [DATA_SIZE-1:0] i_B_WData,
    output logic                 o_A_Gnt,
    output logic                 o_B_Gnt,
    output logic                 o_A_RValid,
    output logic [DATA_SIZE-1:0] o_A_RData,
    output logic                 o_B_RValid,
    output logic [DATA_SIZE-1:0] o_B_RData,
    output logic [ADDR_SIZE-1:0] o_Addr,
    output logic                 o_EN,
    output logic [WEN_SIZE-1:0]  o_WEN,
    output logic [DATA_SIZE-1:0] o_WData,
    input  logic [DATA_SIZE-1:0] i_RData
);

    localparam logic [7:0] c_MAX_BURST = 8'(MAX_BURST);
    localparam logic       c_REQ_A     = 1'b0;
    localparam logic       c_REQ_B     = 1'b1;

    // Arbitration state
    logic                 r_Last;
    logic                 r_Owner_Valid;
    logic [7:0]           r_Burst;

    // Tag pipeline: stage k holds the tag of the read accepted k edges ago
    logic [RD_LAT:0]      r_Tag_V;
    logic [RD_LAT:0]      r_Tag_R;

    // Registered outputs
    logic [ADDR_SIZE-1:0] r_Addr;
    logic                 r_EN;
    logic [WEN_SIZE-1:0]  r_WEN;
    logic [DATA_SIZE-1:0] r_WData;
    logic                 r_A_RValid;
    logic [DATA_SIZE-1:0] r_A_RData;
    logic                 r_B_RValid;
    logic [DATA_SIZE-1:0] r_B_RData;

    logic                 w_Gnt_A;
    logic                 w_Gnt_B;
    logic                 w_Accept;
    logic                 w_Sel;
    logic                 w_Wr;
    logic [ADDR_SIZE-1:0] w_Addr;
    logic [DATA_SIZE-1:0] w_WData;
    logic                 w_Same_Owner;

    // Grant: a lone request wins; on a tie the current owner keeps the port
    // until its burst budget is used up, otherwise the other side gets it.
    always_comb begin
        w_Gnt_A = 1'b0;
        w_Gnt_B = 1'b0;
        if (rstn) begin
            if (i_A_Req && !i_B_Req) begin
                w_Gnt_A = 1'b1;
            end else if (!i_A_Req && i_B_Req) begin
                w_Gnt_B = 1'b1;
            end else if (i_A_Req && i_B_Req) begin
                if (r_Owner_Valid && (r_Burst < c_MAX_BURST)) begin
                    w_Gnt_A = (r_Last == c_REQ_A);
                    w_Gnt_B = (r_Last == c_REQ_B);
                end else begin
                    w_Gnt_A = (r_Last == c_REQ_B);
                    w_Gnt_B = (r_Last == c_REQ_A);
                end
            end
        end
    end

    assign w_Accept     = w_Gnt_A | w_Gnt_B;
    assign w_Sel        = w_Gnt_B;
    assign w_Wr         = w_Sel ? i_B_Wr    : i_A_Wr;
    assign w_Addr       = w_Sel ? i_B_Addr  : i_A_Addr;
    assign w_WData      = w_Sel ? i_B_WData : i_A_WData;
    assign w_Same_Owner = r_Owner_Valid && (r_Last == w_Sel);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_Last        <= c_REQ_B;   // A wins the first tie
            r_Owner_Valid <= 1'b0;
            r_Burst       <= 8'd0;
            r_Tag_V       <= '0;
            r_Tag_R       <= '0;
            r_Addr        <= '0;
            r_EN          <= 1'b0;
            r_WEN         <= '0;
            r_WData       <= '0;
            r_A_RValid    <= 1'b0;
            r_A_RData     <= '0;
            r_B_RValid    <= 1'b0;
            r_B_RData     <= '0;
        end else begin
            if (w_Accept) begin
                r_EN          <= 1'b1;
                r_Addr        <= w_Addr;
                r_WData       <= w_WData;
                r_WEN         <= {WEN_SIZE{w_Wr}};
                r_Last        <= w_Sel;
                r_Owner_Valid <= 1'b1;
                if (w_Same_Owner) begin
                    // Saturate: an unopposed owner may run past the limit
                    if (r_Burst < c_MAX_BURST) begin
                        r_Burst <= r_Burst + 8'd1;
                    end
                end else begin
                    r_Burst <= 8'd1;
                end
            end else begin
                r_EN          <= 1'b0;
                r_WEN         <= '0;
                r_Owner_Valid <= 1'b0;
                r_Burst       <= 8'd0;
            end

            r_Tag_V <= {r_Tag_V[RD_LAT-1:0], (w_Accept & ~w_Wr)};
            r_Tag_R <= {r_Tag_R[RD_LAT-1:0], w_Sel};

            // Stage RD_LAT lines up with the BRAM data on i_RData
            r_A_RValid <= 1'b0;
            r_B_RValid <= 1'b0;
            if (r_Tag_V[RD_LAT]) begin
                if (r_Tag_R[RD_LAT] == c_REQ_B) begin
                    r_B_RValid <= 1'b1;
                    r_B_RData  <= i_RData;
                end else begin
                    r_A_RValid <= 1'b1;
                    r_A_RData  <= i_RData;
                end
            end
        end
    end

    assign o_A_Gnt    = w_Gnt_A;
    assign o_B_Gnt    = w_Gnt_B;
    assign o_Addr     = r_Addr;
    assign o_EN       = r_EN;
    assign o_WEN      = r_WEN;
    assign o_WData    = r_WData;
    assign o_A_RValid = r_A_RValid;
    assign o_A_RData  = r_A_RData;
    assign o_B_RValid = r_B_RValid;
    assign o_B_RData  = r_B_RData;

endmodule
`default_nettype wire

// File: tb/tb_bram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_bram_port_arbiter
// Description : Bench for bram_port_arbiter. Two instances (RD_LAT=2 and 3)
//               share the same stimulus, each with its own BRAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bram_port_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        a_req = 1'b0, b_req = 1'b0, a_wr = 1'b0, b_wr = 1'b0;
    logic [15:0] a_addr = '0, b_addr = '0;
    logic [31:0] a_wd = '0, b_wd = '0;

    logic        ga [2];
    logic        gb [2];
    logic        rva[2];
    logic        rvb[2];
    logic [31:0] rda[2];
    logic [31:0] rdb[2];
    logic [15:0] addr[2];
    logic        en [2];
    logic [3:0]  wen[2];
    logic [31:0] wd [2];
    logic [31:0] ird[2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bram_port_arbiter #(.RD_LAT(2)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr), .i_A_WData(a_wd),
        .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr), .i_B_WData(b_wd),
        .o_A_Gnt(ga[0]), .o_B_Gnt(gb[0]),
        .o_A_RValid(rva[0]), .o_A_RData(rda[0]),
        .o_B_RValid(rvb[0]), .o_B_RData(rdb[0]),
        .o_Addr(addr[0]), .o_EN(en[0]), .o_WEN(wen[0]), .o_WData(wd[0]),
        .i_RData(ird[0])
    );

    bram_port_arbiter #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rstn(rstn),
        .i_A_Req(a_req), .i_A_Wr(a_wr), .i_A_Addr(a_addr), .i_A_WData(a_wd),
        .i_B_Req(b_req), .i_B_Wr(b_wr), .i_B_Addr(b_addr), .i_B_WData(b_wd),
        .o_A_Gnt(ga[1]), .o_B_Gnt(gb[1]),
        .o_A_RValid(rva[1]), .o_A_RData(rda[1]),
        .o_B_RValid(rvb[1]), .o_B_RData(rdb[1]),
        .o_Addr(addr[1]), .o_EN(en[1]), .o_WEN(wen[1]), .o_WData(wd[1]),
        .i_RData(ird[1])
    );

    // BRAM models: sample on the edge where EN is high, data RD_LAT later
    logic [31:0] mem[2][64];
    logic [31:0] rp [2][4];

    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (en[j]) begin
                if (wen[j] != 4'h0) mem[j][addr[j][5:0]] <= wd[j];
                rp[j][0] <= mem[j][addr[j][5:0]];
            end
            for (int k = 1; k < 4; k++) rp[j][k] <= rp[j][k-1];
        end
    end
    assign ird[0] = rp[0][1];
    assign ird[1] = rp[1][2];

    function automatic int lat(input int j);
        return (j == 0) ? 2 : 3;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        a_req = 1'b0; b_req = 1'b0; a_wr = 1'b0; b_wr = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int j = 0; j < 2; j++) begin
            chk({tag, "_gnt"},   {ga[j], gb[j]}, 2'b00);
            chk({tag, "_en"},    en[j], 1'b0);
            chk({tag, "_wen"},   wen[j], 4'h0);
            chk({tag, "_addr"},  addr[j], 16'h0);
            chk({tag, "_wdata"}, wd[j], 32'h0);
            chk({tag, "_rvalid"}, {rva[j], rvb[j]}, 2'b00);
            chk({tag, "_rdata_a"}, rda[j], 32'h0);
            chk({tag, "_rdata_b"}, rdb[j], 32'h0);
        end
    endtask

    // Single-requester transfer, one cycle
    task automatic xfer(input logic is_b, input logic wr, input logic [15:0] ad,
                        input logic [31:0] d);
        idle_inputs();
        if (is_b) begin b_req = 1'b1; b_wr = wr; b_addr = ad; b_wd = d; end
        else      begin a_req = 1'b1; a_wr = wr; a_addr = ad; a_wd = d; end
        #4;
        for (int j = 0; j < 2; j++) chk("xfer_gnt", {ga[j], gb[j]}, is_b ? 2'b01 : 2'b10);
        tick();
    endtask

    task automatic do_reset();
        idle_inputs();
        #2 rstn = 1'b0;
        tick();
        tick();
        #2 rstn = 1'b1;
        tick();
    endtask

    typedef struct {
        logic        a_req, b_req, a_wr, b_wr;
        logic [15:0] a_addr, b_addr;
        logic [31:0] a_wd, b_wd;
        logic        e_ga, e_gb, e_en;
        logic [3:0]  e_wen;
        logic [15:0] e_addr;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[10];

    initial begin
        // A writes 0..2, idle, tie after idle goes to B, B keeps it, etc.
        vecs[0] = '{1'b1,1'b0,1'b1,1'b0,16'h0,16'h0,32'h11,32'h0, 1'b1,1'b0,1'b1,4'hF,16'h0,32'h11};
        vecs[1] = '{1'b1,1'b0,1'b1,1'b0,16'h1,16'h0,32'h22,32'h0, 1'b1,1'b0,1'b1,4'hF,16'h1,32'h22};
        vecs[2] = '{1'b1,1'b0,1'b1,1'b0,16'h2,16'h0,32'h33,32'h0, 1'b1,1'b0,1'b1,4'hF,16'h2,32'h33};
        vecs[3] = '{1'b0,1'b0,1'b0,1'b0,16'h0,16'h0,32'h0,32'h0,  1'b0,1'b0,1'b0,4'h0,16'h2,32'h33};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b1,16'h7,16'h8,32'h77,32'h88, 1'b0,1'b1,1'b1,4'hF,16'h8,32'h88};
        vecs[5] = '{1'b1,1'b1,1'b1,1'b1,16'h7,16'h9,32'h77,32'h99, 1'b0,1'b1,1'b1,4'hF,16'h9,32'h99};
        vecs[6] = '{1'b1,1'b0,1'b1,1'b0,16'h3,16'h0,32'h44,32'h0, 1'b1,1'b0,1'b1,4'hF,16'h3,32'h44};
        vecs[7] = '{1'b0,1'b0,1'b0,1'b0,16'h0,16'h0,32'h0,32'h0,  1'b0,1'b0,1'b0,4'h0,16'h3,32'h44};
        vecs[8] = '{1'b0,1'b1,1'b0,1'b0,16'h0,16'hA,32'h0,32'h5,  1'b0,1'b1,1'b1,4'h0,16'hA,32'h5};
        vecs[9] = '{1'b0,1'b0,1'b0,1'b0,16'h0,16'h0,32'h0,32'h0,  1'b0,1'b0,1'b0,4'h0,16'hA,32'h5};

        // ---------------- reset state ----------------
        tick();
        tick();
        chk_reset_outputs("reset");
        a_req = 1'b1; b_req = 1'b1;
        #1;
        for (int j = 0; j < 2; j++) chk("gnt_in_reset", {ga[j], gb[j]}, 2'b00);
        idle_inputs();
        #1 rstn = 1'b1;
        tick();

        // ---------------- table-driven vectors ----------------
        for (int v = 0; v < 10; v++) begin
            a_req = vecs[v].a_req; b_req = vecs[v].b_req;
            a_wr = vecs[v].a_wr;   b_wr = vecs[v].b_wr;
            a_addr = vecs[v].a_addr; b_addr = vecs[v].b_addr;
            a_wd = vecs[v].a_wd;   b_wd = vecs[v].b_wd;
            #4;
            for (int j = 0; j < 2; j++) begin
                chk("vec_gnt_a", ga[j], vecs[v].e_ga);
                chk("vec_gnt_b", gb[j], vecs[v].e_gb);
            end
            tick();
            for (int j = 0; j < 2; j++) begin
                chk("vec_en",    en[j],   vecs[v].e_en);
                chk("vec_wen",   wen[j],  vecs[v].e_wen);
                chk("vec_addr",  addr[j], vecs[v].e_addr);
                chk("vec_wdata", wd[j],   vecs[v].e_wd);
            end
        end

        // ---------------- burst limit: A x8, B x8, A x4 ----------------
        do_reset();
        for (int i = 0; i < 20; i++) begin
            logic exp_a;
            a_req = 1'b1; b_req = 1'b1; a_wr = 1'b1; b_wr = 1'b1;
            a_addr = 16'(16'h10 + i); b_addr = 16'(16'h20 + i);
            a_wd = 32'(i); b_wd = 32'(i + 100);
            exp_a = (i < 8) || (i >= 16);
            #4;
            for (int j = 0; j < 2; j++) begin
                chk("burst_gnt_a", ga[j], exp_a);
                chk("burst_gnt_b", gb[j], !exp_a);
            end
            tick();
        end
        idle_inputs();
        tick();

        // ---------------- read after write, returned to B ----------------
        xfer(1'b0, 1'b1, 16'h5, 32'hDEADBEEF);
        xfer(1'b1, 1'b0, 16'h5, 32'h0);   // accept edge N; now at N+1ns
        idle_inputs();
        for (int k = 1; k <= 6; k++) begin
            tick();
            for (int j = 0; j < 2; j++) begin
                chk("raw_rvalid_b", rvb[j], (k == lat(j) + 1));
                chk("raw_rvalid_a", rva[j], 1'b0);
                if (k == lat(j) + 1) chk("raw_rdata_b", rdb[j], 32'hDEADBEEF);
            end
        end

        // ---------------- interleaved reads A@1, B@2, A@3 ----------------
        xfer(1'b0, 1'b1, 16'h1, 32'hA1A1A1A1);
        xfer(1'b0, 1'b1, 16'h2, 32'hB2B2B2B2);
        xfer(1'b0, 1'b1, 16'h3, 32'hA3A3A3A3);
        xfer(1'b0, 1'b0, 16'h1, 32'h0);   // edge N
        xfer(1'b1, 1'b0, 16'h2, 32'h0);   // edge N+1
        xfer(1'b0, 1'b0, 16'h3, 32'h0);   // edge N+2
        idle_inputs();
        for (int k = 3; k <= 8; k++) begin
            tick();
            for (int j = 0; j < 2; j++) begin
                chk("ilv_rvalid_a", rva[j], (k == lat(j) + 1) || (k == lat(j) + 3));
                chk("ilv_rvalid_b", rvb[j], (k == lat(j) + 2));
                if (k == lat(j) + 1) chk("ilv_rdata_a1", rda[j], 32'hA1A1A1A1);
                if (k == lat(j) + 2) chk("ilv_rdata_b2", rdb[j], 32'hB2B2B2B2);
                if (k == lat(j) + 3) chk("ilv_rdata_a3", rda[j], 32'hA3A3A3A3);
            end
        end

        // ---------------- reset shortly after a read accept ----------------
        xfer(1'b0, 1'b0, 16'h1, 32'h0);   // accept edge N
        idle_inputs();
        tick();                           // N+1
        a_req = 1'b1; b_req = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        tick();
        tick();
        #2 rstn = 1'b1;
        #1;
        for (int j = 0; j < 2; j++) chk("tie_after_reset", {ga[j], gb[j]}, 2'b10);
        idle_inputs();
        for (int k = 0; k < 6; k++) begin
            tick();
            for (int j = 0; j < 2; j++) chk("no_rvalid_after_reset", {rva[j], rvb[j]}, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
